// File: rtl/ucode_mul_seq_if.sv
// ucode_mul_seq_if -- handshake/bus bundle for the multiply micro-op sequencer.
//   master : issues start requests with fields and accepts micro-ops (uop_ready)
//   slave  : the sequencer; returns start_ready, micro-op stream, busy/done/err
// Signals:
//   start, start_ready, dest_reg, source_reg, immediate, start_signed
//   uop_valid, uop_ready, uop_kind, uop_dest, uop_src, uop_shamt
//   busy, done, err
interface ucode_mul_seq_if #(
  parameter int REG_W = 4,
  parameter int IMM_W = 16
);
  localparam int SHAMT_W = $clog2(IMM_W);

  logic               start;
  logic               start_ready;
  logic [REG_W-1:0]   dest_reg;
  logic [REG_W-1:0]   source_reg;
  logic [IMM_W-1:0]   immediate;
  logic               start_signed;
  logic               uop_valid;
  logic               uop_ready;
  logic [2:0]         uop_kind;
  logic [REG_W-1:0]   uop_dest;
  logic [REG_W-1:0]   uop_src;
  logic [SHAMT_W-1:0] uop_shamt;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output start, dest_reg, source_reg, immediate, start_signed, uop_ready,
    input  start_ready, uop_valid, uop_kind, uop_dest, uop_src, uop_shamt,
           busy, done, err
  );

  modport slave (
    input  start, dest_reg, source_reg, immediate, start_signed, uop_ready,
    output start_ready, uop_valid, uop_kind, uop_dest, uop_src, uop_shamt,
           busy, done, err
  );
endinterface

// File: rtl/ucode_mul_seq.sv
// ucode_mul_seq -- expands a multiply-by-immediate macro-op into a stream of
// micro-ops: COPY scratch<-src, CLR dest, one ADDSHL per set multiplier bit
// (lowest bit first), and optionally a trailing NEG.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ucode_mul_seq_if.slave (start request, micro-op stream, status)
// Optional feature macro: UCODE_NEG_EN -- signed immediates; a negative
//   multiplier is expanded by its magnitude followed by a NEG of dest.
module ucode_mul_seq #(
  parameter int REG_W       = 4,
  parameter int IMM_W       = 16,
  parameter int SCRATCH_REG = 15
) (
  input logic            clk,
  input logic            rst,
  ucode_mul_seq_if.slave bus
);
  localparam int SHAMT_W = $clog2(IMM_W);
  localparam logic [REG_W-1:0] SCR = REG_W'(SCRATCH_REG);

  localparam logic [2:0] K_COPY = 3'd1;
  localparam logic [2:0] K_CLR  = 3'd2;
  localparam logic [2:0] K_ADD  = 3'd3;
  localparam logic [2:0] K_NEG  = 3'd4;

  typedef enum logic [2:0] {IDLE, COPY, CLR, ADD, NEG} state_t;

  typedef struct packed {
    logic               valid;
    logic [2:0]         kind;
    logic [REG_W-1:0]   dest;
    logic [REG_W-1:0]   src;
    logic [SHAMT_W-1:0] shamt;
  } uop_t;

  localparam uop_t UOP_NONE = '0;

  // Index of the lowest set bit; 0 when v == 0 (never used in that case).
  function automatic logic [SHAMT_W-1:0] low_bit(input logic [IMM_W-1:0] v);
    low_bit = '0;
    for (int i = IMM_W-1; i >= 0; i--)
      if (v[i]) low_bit = SHAMT_W'(i);
  endfunction

  function automatic uop_t mk(input logic [2:0] k, input logic [REG_W-1:0] d,
                              input logic [REG_W-1:0] s,
                              input logic [SHAMT_W-1:0] sh);
    mk = '{valid: 1'b1, kind: k, dest: d, src: s, shamt: sh};
  endfunction

  state_t           state_q;
  logic [REG_W-1:0] dest_q;
  logic [IMM_W-1:0] rem_q;
  logic             neg_q;
  uop_t             uop_q;
  logic             done_q;
  logic             err_q;

  logic             hs;
  logic             reject;
  logic [IMM_W-1:0] rem_d;
  logic [IMM_W-1:0] cap_mag;
  logic             cap_neg;

`ifdef UCODE_NEG_EN
  assign cap_neg = bus.start_signed & bus.immediate[IMM_W-1];
  assign cap_mag = cap_neg ? ({IMM_W{1'b0}} - bus.immediate) : bus.immediate;
`else
  logic unused_signed;
  assign unused_signed = bus.start_signed;
  assign cap_neg = 1'b0;
  assign cap_mag = bus.immediate;
`endif

  assign hs     = uop_q.valid & bus.uop_ready;
  assign reject = (bus.dest_reg == SCR) || (bus.source_reg == SCR);
  // Remaining magnitude with its lowest set bit cleared.
  assign rem_d  = rem_q & (rem_q - {{(IMM_W-1){1'b0}}, 1'b1});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      dest_q  <= '0;
      rem_q   <= '0;
      neg_q   <= 1'b0;
      uop_q   <= UOP_NONE;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            if (reject) begin
              err_q <= 1'b1;
            end else begin
              dest_q  <= bus.dest_reg;
              rem_q   <= cap_mag;
              neg_q   <= cap_neg;
              state_q <= COPY;
              uop_q   <= mk(K_COPY, SCR, bus.source_reg, '0);
            end
          end
        end
        COPY: if (hs) begin
          state_q <= CLR;
          uop_q   <= mk(K_CLR, dest_q, '0, '0);
        end
        CLR: if (hs) begin
          if (rem_q != '0) begin
            state_q <= ADD;
            uop_q   <= mk(K_ADD, dest_q, SCR, low_bit(rem_q));
          end else begin
            state_q <= IDLE;
            uop_q   <= UOP_NONE;
            done_q  <= 1'b1;
          end
        end
        ADD: if (hs) begin
          rem_q <= rem_d;
          if (rem_d != '0) begin
            uop_q <= mk(K_ADD, dest_q, SCR, low_bit(rem_d));
          end else if (neg_q) begin
            state_q <= NEG;
            uop_q   <= mk(K_NEG, dest_q, '0, '0);
          end else begin
            state_q <= IDLE;
            uop_q   <= UOP_NONE;
            done_q  <= 1'b1;
          end
        end
        NEG: if (hs) begin
          state_q <= IDLE;
          uop_q   <= UOP_NONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          uop_q   <= UOP_NONE;
        end
      endcase
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.uop_valid   = uop_q.valid;
  assign bus.uop_kind    = uop_q.kind;
  assign bus.uop_dest    = uop_q.dest;
  assign bus.uop_src     = uop_q.src;
  assign bus.uop_shamt   = uop_q.shamt;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
endmodule

// File: tb/tb_ucode_mul_seq.sv
module tb_ucode_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  // expected micro-op stream: kind, dest, src, shamt
  int ek[$], ed[$], es[$], eh[$];

  always #5 clk = ~clk;

  ucode_mul_seq_if #(.REG_W(4), .IMM_W(16)) bus ();

  ucode_mul_seq #(.REG_W(4), .IMM_W(16), .SCRATCH_REG(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: multiply by shift-and-add over the set bits of the magnitude.
  task automatic build(input int d, input int s, input int imm, input bit sg);
    int  mag;
    bit  neg;
    mag = imm & 16'hFFFF;
    neg = 1'b0;
`ifdef UCODE_NEG_EN
    if (sg && imm[15]) begin
      neg = 1'b1;
      mag = (65536 - mag) % 65536;
    end
`endif
    ek.delete(); ed.delete(); es.delete(); eh.delete();
    ek.push_back(1); ed.push_back(15); es.push_back(s); eh.push_back(0);
    ek.push_back(2); ed.push_back(d);  es.push_back(0); eh.push_back(0);
    for (int b = 0; b < 16; b++)
      if ((mag >> b) & 1) begin
        ek.push_back(3); ed.push_back(d); es.push_back(15); eh.push_back(b);
      end
    if (neg) begin
      ek.push_back(4); ed.push_back(d); es.push_back(0); eh.push_back(0);
    end
  endtask

  // Called at a negedge. mode 0: ready always 1 (also checks latency);
  // mode 1: random ready plus stray starts while busy; mode 2: 1,0,0,1 during ADD.
  task automatic run_seq(input int d, input int s, input int imm, input bit sg, input int mode);
    int n, cyc, k;
    bit rdy;
    bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    build(d, s, imm, sg);
    n = ek.size();
    chk("start_ready_idle", bus.start_ready, 1);
    bus.start = 1'b1;
    bus.dest_reg = 4'(d); bus.source_reg = 4'(s);
    bus.immediate = 16'(imm); bus.start_signed = sg;
    bus.uop_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1; k = 0;
    while (ek.size() > 0 && cyc < 400) begin
      chk("uop_valid", bus.uop_valid, 1);
      chk("busy", bus.busy, 1);
      chk("start_ready_busy", bus.start_ready, 0);
      chk("err_busy", bus.err, 0);
      chk("done_busy", bus.done, 0);
      chk("kind", bus.uop_kind, ek[0]);
      chk("dest", bus.uop_dest, ed[0]);
      chk("shamt", bus.uop_shamt, eh[0]);
      if (ek[0] == 1 || ek[0] == 3) chk("src", bus.uop_src, es[0]);
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: begin
          if (ek[0] == 3) begin rdy = pat[k % 4]; k++; end
          else rdy = 1'b1;
        end
      endcase
      if (mode == 1) begin
        bus.start = ($urandom_range(0, 3) == 0);
        bus.dest_reg = 4'($urandom); bus.source_reg = 4'($urandom);
        bus.immediate = 16'($urandom);
      end
      bus.uop_ready = rdy;
      if (rdy) begin
        void'(ek.pop_front()); void'(ed.pop_front());
        void'(es.pop_front()); void'(eh.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    bus.uop_ready = 1'b1;
    chk("seq_complete", ek.size(), 0);
    chk("done", bus.done, 1);
    chk("busy_end", bus.busy, 0);
    chk("start_ready_end", bus.start_ready, 1);
    chk("valid_end", bus.uop_valid, 0);
    chk("idle_fields", {bus.uop_kind, bus.uop_dest, bus.uop_src, bus.uop_shamt}, 0);
    if (mode == 0) chk("latency", cyc, n + 1);
  endtask

  task automatic reject_start(input int d, input int s);
    bus.start = 1'b1;
    bus.dest_reg = 4'(d); bus.source_reg = 4'(s);
    bus.immediate = 16'h1234; bus.start_signed = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    chk("rej_err", bus.err, 1);
    chk("rej_valid", bus.uop_valid, 0);
    chk("rej_busy", bus.busy, 0);
    chk("rej_ready", bus.start_ready, 1);
    @(negedge clk);
    chk("rej_err_pulse", bus.err, 0);
    chk("rej_valid2", bus.uop_valid, 0);
    chk("rej_busy2", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0; bus.dest_reg = '0; bus.source_reg = '0;
    bus.immediate = '0; bus.start_signed = 1'b0; bus.uop_ready = 1'b1;
    @(negedge clk);
    chk("rst_valid", bus.uop_valid, 0);
    chk("rst_fields", {bus.uop_kind, bus.uop_dest, bus.uop_src, bus.uop_shamt}, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ready", bus.start_ready, 1);
    chk("rst_done_err", {bus.done, bus.err}, 0);
    rst = 1'b0;
    @(negedge clk);

    run_seq(2, 3, 16'h000A, 1'b0, 0);
    run_seq(5, 1, 16'h0000, 1'b0, 0);   // started in the done cycle
    run_seq(7, 4, 16'hFFFF, 1'b0, 0);
    run_seq(2, 3, 16'h00F6, 1'b0, 2);
    run_seq(3, 6, 16'hFFFD, 1'b1, 0);
    run_seq(1, 0, 16'h8000, 1'b1, 0);
    @(negedge clk);
    reject_start(15, 3);
    reject_start(4, 15);

    // reset during the second ADD of imm=7
    bus.start = 1'b1; bus.dest_reg = 4'd2; bus.source_reg = 4'd3;
    bus.immediate = 16'h0007; bus.start_signed = 1'b0; bus.uop_ready = 1'b1;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_kind", bus.uop_kind, 3);
    chk("pre_rst_shamt", bus.uop_shamt, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.uop_valid, 0);
    chk("mid_rst_fields", {bus.uop_kind, bus.uop_dest, bus.uop_src, bus.uop_shamt}, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.start_ready, 1);
    chk("mid_rst_done_err", {bus.done, bus.err}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", bus.uop_valid, 0);
    chk("post_rst_busy", bus.busy, 0);
    run_seq(2, 3, 16'h0007, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      int d, s, imm, mode;
      d = $urandom_range(0, 14);
      s = $urandom_range(0, 14);
      imm = ($urandom_range(0, 1) != 0) ? int'($urandom & 16'hFFFF)
                                        : int'($urandom & $urandom & 16'hFFFF);
      mode = $urandom_range(0, 2);
      run_seq(d, s, imm, 1'($urandom_range(0, 1)), mode);
      if ($urandom_range(0, 1) != 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
